// File: rtl/screen_ctrl_if.sv
// Screen-select bundle between the game-flow controller and its neighbours (buttons, scores, bg drawer).
interface screen_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               vblnk;
    logic               btn_single;
    logic               btn_multi;
    logic               btn_back;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               screen_single;
    logic               screen_multi;
    logic               game_over;
    logic [1:0]         winner;
    logic               game_rst;

    modport master (
        output vblnk, btn_single, btn_multi, btn_back, score_left, score_right,
        input  screen_single, screen_multi, game_over, winner, game_rst
    );

    modport slave (
        input  vblnk, btn_single, btn_multi, btn_back, score_left, score_right,
        output screen_single, screen_multi, game_over, winner, game_rst
    );
endinterface

// File: rtl/screen_ctrl.sv
// Game-flow controller: IDLE / SINGLE / MULTI / OVER, switching only at vblnk rise.
// Outputs registered from next state (1 clk after first vblnk-high cycle); no backpressure, button rises are latched per frame.
module screen_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int OVER_FRAMES = 180,
    parameter int SCORE_W     = 4
) (
    input  logic          i_clk65MHz,
    input  logic          i_rst,
    screen_ctrl_if.slave  io_scr
);
    localparam int CNT_W = $clog2(OVER_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OVER_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_MULTI, S_OVER} state_t;
    typedef enum logic [1:0] {P_NONE, P_SINGLE, P_MULTI, P_BACK} pend_t;

    state_t             r_state, w_state_nxt;
    pend_t              r_pend, w_pend_nxt, w_rise_req;
    logic               r_mode_multi, w_mode_multi_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               r_vblnk_q, r_btn_s_q, r_btn_m_q, r_btn_b_q;
    logic               r_scr_single, r_scr_multi, r_game_over, r_game_rst;
    logic               w_scr_single_nxt, w_scr_multi_nxt, w_game_over_nxt, w_game_rst_nxt;
    logic               w_tick, w_rise_s, w_rise_m, w_rise_b;
    logic               w_left_win, w_right_win;
    logic [SCORE_W-1:0] w_score_l, w_score_r;

    assign w_score_l   = io_scr.score_left;
    assign w_score_r   = io_scr.score_right;
    assign w_left_win  = int'(w_score_l) >= WIN_SCORE;
    assign w_right_win = int'(w_score_r) >= WIN_SCORE;

    assign w_tick   = io_scr.vblnk      & ~r_vblnk_q;
    assign w_rise_s = io_scr.btn_single & ~r_btn_s_q;
    assign w_rise_m = io_scr.btn_multi  & ~r_btn_m_q;
    assign w_rise_b = io_scr.btn_back   & ~r_btn_b_q;

    always_comb begin
        w_rise_req       = P_NONE;
        if (w_rise_b)      w_rise_req = P_BACK;
        else if (w_rise_m) w_rise_req = P_MULTI;
        else if (w_rise_s) w_rise_req = P_SINGLE;

        w_state_nxt      = r_state;
        w_mode_multi_nxt = r_mode_multi;
        w_cnt_nxt        = r_cnt;
        w_winner_nxt     = r_winner;
        w_game_rst_nxt   = 1'b0;
        w_pend_nxt       = (w_rise_req != P_NONE) ? w_rise_req : r_pend;

        if (w_tick) begin
            // The pending request is consumed (or dropped) at every frame; a rise on this cycle carries over.
            w_pend_nxt = w_rise_req;
            case (r_state)
                S_IDLE: begin
                    if (r_pend == P_SINGLE || r_pend == P_MULTI) begin
                        w_state_nxt      = (r_pend == P_MULTI) ? S_MULTI : S_SINGLE;
                        w_mode_multi_nxt = (r_pend == P_MULTI);
                        w_game_rst_nxt   = 1'b1;
                    end
                end
                S_SINGLE, S_MULTI: begin
                    if (r_pend == P_BACK) begin
                        w_state_nxt  = S_IDLE;
                        w_winner_nxt = 2'b00;
                    end else if (w_left_win || w_right_win) begin
                        w_state_nxt  = S_OVER;
                        w_winner_nxt = {w_right_win, w_left_win};
                        w_cnt_nxt    = CNT_INIT;
                    end
                end
                S_OVER: begin
                    if (r_pend == P_BACK || r_cnt == '0) begin
                        w_state_nxt  = S_IDLE;
                        w_winner_nxt = 2'b00;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_winner_nxt = 2'b00;
                end
            endcase
        end

        w_scr_single_nxt = (w_state_nxt == S_SINGLE) || (w_state_nxt == S_OVER && !w_mode_multi_nxt);
        w_scr_multi_nxt  = (w_state_nxt == S_MULTI)  || (w_state_nxt == S_OVER &&  w_mode_multi_nxt);
        w_game_over_nxt  = (w_state_nxt == S_OVER);
    end

    always_ff @(posedge i_clk65MHz) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pend       <= P_NONE;
            r_mode_multi <= 1'b0;
            r_cnt        <= '0;
            r_winner     <= 2'b00;
            r_vblnk_q    <= 1'b0;
            // Buttons held through reset must not look like fresh presses.
            r_btn_s_q    <= 1'b1;
            r_btn_m_q    <= 1'b1;
            r_btn_b_q    <= 1'b1;
            r_scr_single <= 1'b0;
            r_scr_multi  <= 1'b0;
            r_game_over  <= 1'b0;
            r_game_rst   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend       <= w_pend_nxt;
            r_mode_multi <= w_mode_multi_nxt;
            r_cnt        <= w_cnt_nxt;
            r_winner     <= w_winner_nxt;
            r_vblnk_q    <= io_scr.vblnk;
            r_btn_s_q    <= io_scr.btn_single;
            r_btn_m_q    <= io_scr.btn_multi;
            r_btn_b_q    <= io_scr.btn_back;
            r_scr_single <= w_scr_single_nxt;
            r_scr_multi  <= w_scr_multi_nxt;
            r_game_over  <= w_game_over_nxt;
            r_game_rst   <= w_game_rst_nxt;
        end
    end

    assign io_scr.screen_single = r_scr_single;
    assign io_scr.screen_multi  = r_scr_multi;
    assign io_scr.game_over     = r_game_over;
    assign io_scr.winner        = r_winner;
    assign io_scr.game_rst      = r_game_rst;
endmodule

// File: tb/tb_screen_ctrl.sv
// Directed scenarios plus random buttons/scores, every cycle compared against a frame-level game model.
module tb_screen_ctrl;
    localparam int WIN = 10;
    localparam int OF  = 180;

    logic clk;
    logic rst;
    screen_ctrl_if bus ();

    screen_ctrl dut (
        .i_clk65MHz (clk),
        .i_rst      (rst),
        .io_scr     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Game model: phase 0=menu, 1=playing, 2=results screen.
    int         m_phase, m_mode, m_frames_left, m_req;
    bit         pv, ps, pm, pb;
    logic [1:0] m_win;
    bit         m_gr;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int newreq;
        int sl, sr;
        if (rst) begin
            m_phase = 0; m_mode = 0; m_frames_left = 0; m_req = 0;
            pv = 0; ps = 1; pm = 1; pb = 1; m_win = 2'b00; m_gr = 0;
            return;
        end
        newreq = 0;
        if (bus.btn_back && !pb)        newreq = 3;
        else if (bus.btn_multi && !pm)  newreq = 2;
        else if (bus.btn_single && !ps) newreq = 1;
        sl = int'(bus.score_left);
        sr = int'(bus.score_right);
        m_gr = 0;
        if (bus.vblnk && !pv) begin
            if (m_phase == 0) begin
                if (m_req == 1 || m_req == 2) begin
                    m_phase = 1; m_mode = m_req; m_gr = 1;
                end
            end else if (m_phase == 1) begin
                if (m_req == 3) m_phase = 0;
                else if (sl >= WIN || sr >= WIN) begin
                    m_phase = 2;
                    m_win = {sr >= WIN, sl >= WIN};
                    m_frames_left = OF - 1;
                end
            end else begin
                if (m_req == 3 || m_frames_left == 0) begin
                    m_phase = 0; m_win = 2'b00;
                end else m_frames_left--;
            end
            m_req = newreq;
        end else if (newreq != 0) m_req = newreq;
        pv = bus.vblnk; ps = bus.btn_single; pm = bus.btn_multi; pb = bus.btn_back;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("screen_single", bus.screen_single, (m_phase != 0 && m_mode == 1));
        chk("screen_multi",  bus.screen_multi,  (m_phase != 0 && m_mode == 2));
        chk("game_over",     bus.game_over,     (m_phase == 2));
        chk("winner",        bus.winner,        m_win);
        chk("game_rst",      bus.game_rst,      m_gr);
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            bus.vblnk = 1'b1; cyc(); cyc();
            bus.vblnk = 1'b0; repeat (6) cyc();
        end
    endtask

    task automatic press(input int which);
        if (which == 1) bus.btn_single = 1'b1;
        if (which == 2) bus.btn_multi  = 1'b1;
        if (which == 3) bus.btn_back   = 1'b1;
        cyc(); cyc();
        bus.btn_single = 1'b0; bus.btn_multi = 1'b0; bus.btn_back = 1'b0;
        cyc();
    endtask

    initial begin
        bus.vblnk = 1'b0; bus.btn_single = 1'b1; bus.btn_multi = 1'b0; bus.btn_back = 1'b0;
        bus.score_left = '0; bus.score_right = '0;
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_single", bus.screen_single, 1'b0);
        chk("reset_winner", bus.winner, 2'b00);

        // Button held through reset must not start a game
        rst = 1'b0;
        frame(3);
        chk("held_btn_idle", bus.screen_single, 1'b0);
        bus.btn_single = 1'b0;
        cyc();

        // Single-player entry only at the next frame tick
        press(1);
        chk("single_not_before", bus.screen_single, 1'b0);
        bus.vblnk = 1'b1; cyc();
        chk("single_entry", bus.screen_single, 1'b1);
        chk("single_game_rst", bus.game_rst, 1'b1);
        cyc();
        chk("game_rst_one_cycle", bus.game_rst, 1'b0);
        bus.vblnk = 1'b0; repeat (6) cyc();
        press(3); frame(1);
        chk("back_to_idle", bus.screen_single, 1'b0);

        // Multi-player, left wins, full countdown
        press(2); frame(1);
        chk("multi_entry", bus.screen_multi, 1'b1);
        bus.score_left = 4'd10; bus.score_right = 4'd3;
        frame(1);
        chk("over_flag", bus.game_over, 1'b1);
        chk("over_winner_left", bus.winner, 2'b01);
        chk("over_keeps_multi", bus.screen_multi, 1'b1);
        bus.score_left = '0; bus.score_right = '0;
        frame(OF - 1);
        chk("over_last_frame", bus.game_over, 1'b1);
        frame(1);
        chk("over_expired", bus.game_over, 1'b0);
        chk("winner_cleared", bus.winner, 2'b00);

        // Tie, then abort from results screen
        press(1); frame(1);
        bus.score_left = 4'd10; bus.score_right = 4'd10;
        frame(1);
        chk("tie_winner", bus.winner, 2'b11);
        bus.score_left = '0; bus.score_right = '0;
        press(3); frame(1);
        chk("back_from_over", bus.game_over, 1'b0);

        // Simultaneous single+back stays idle; mid-game mode switch ignored
        bus.btn_single = 1'b1; bus.btn_back = 1'b1; cyc(); cyc();
        bus.btn_single = 1'b0; bus.btn_back = 1'b0; cyc();
        frame(1);
        chk("back_beats_single", bus.screen_single, 1'b0);
        press(1); frame(1);
        press(2); frame(2);
        chk("no_mode_switch_s", bus.screen_single, 1'b1);
        chk("no_mode_switch_m", bus.screen_multi, 1'b0);

        // Reset mid-countdown, then fresh multi start
        bus.score_left = 4'd12; frame(1);
        bus.score_left = '0;
        frame(OF - 1 - 50);
        chk("countdown_running", bus.game_over, 1'b1);
        rst = 1'b1; cyc();
        chk("rst_over", bus.game_over, 1'b0);
        chk("rst_single", bus.screen_single, 1'b0);
        rst = 1'b0; cyc();
        press(2);
        bus.vblnk = 1'b1; cyc();
        chk("post_rst_multi", bus.screen_multi, 1'b1);
        chk("post_rst_game_rst", bus.game_rst, 1'b1);
        bus.vblnk = 1'b0; repeat (6) cyc();

        // Random buttons, scores and occasional reset
        for (int c = 0; c < 2000; c++) begin
            bus.vblnk = ((c % 8) < 2);
            if ($urandom_range(0, 19) == 0) bus.btn_single = ~bus.btn_single;
            if ($urandom_range(0, 19) == 0) bus.btn_multi  = ~bus.btn_multi;
            if ($urandom_range(0, 39) == 0) bus.btn_back   = ~bus.btn_back;
            if ((c % 16) == 5) begin
                bus.score_left  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                bus.score_right = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
